// File: rtl/btn_toggle_debounce_pkg.sv
// Switch levels shared by the button front end and the light FSM.
package btn_toggle_debounce_pkg;

  localparam logic LIGHT_ON  = 1'b1;
  localparam logic LIGHT_OFF = 1'b0;

endpackage

// File: rtl/btn_toggle_debounce_sync_ff.sv
// N-flop synchroniser for a raw asynchronous input; clears to 0 on reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/btn_toggle_debounce.sv
// Raw push-button to light on/off level: synchronise, debounce, detect press, toggle.
module btn_toggle_debounce
  import btn_toggle_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100_000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_OnOffSW,
  output logic o_btn_level,
  output logic o_press_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_REL     = 2'd0,
    S_WAIT_DN = 2'd1,
    S_PRESS   = 2'd2,
    S_WAIT_UP = 2'd3
  } state_t;

  logic             s;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .d       (i_btn),
    .q       (s)
  );

  // The counter only advances while a candidate edge holds; any disagreement restarts it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= S_REL;
      cnt           <= '0;
      o_OnOffSW     <= LIGHT_OFF;
      o_btn_level   <= 1'b0;
      o_press_pulse <= 1'b0;
    end else begin
      o_press_pulse <= 1'b0;
      case (state)
        S_REL: begin
          if (s) begin
            state <= S_WAIT_DN;
            cnt   <= '0;
          end
        end
        S_WAIT_DN: begin
          if (!s) begin
            state <= S_REL;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state         <= S_PRESS;
            cnt           <= '0;
            o_btn_level   <= 1'b1;
            o_press_pulse <= 1'b1;
            o_OnOffSW     <= (o_OnOffSW == LIGHT_ON) ? LIGHT_OFF : LIGHT_ON;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_PRESS: begin
          if (!s) begin
            state <= S_WAIT_UP;
            cnt   <= '0;
          end
        end
        S_WAIT_UP: begin
          if (s) begin
            state <= S_PRESS;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= S_REL;
            cnt         <= '0;
            o_btn_level <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state       <= S_REL;
          cnt         <= '0;
          o_btn_level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_toggle_debounce.sv
// Directed bench for btn_toggle_debounce with a pulse scoreboard (DEBOUNCE_CYCLES=4, SYNC_STAGES=2).
module tb_btn_toggle_debounce;

  localparam int DEB = 4;
  localparam int SYN = 2;
  localparam int LAT = SYN + DEB + 1;

  logic clk = 1'b0;
  logic rst;
  logic btn;
  logic onoff;
  logic level;
  logic pulse;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int   at;
    logic onoff;
  } exp_t;

  exp_t sb[$];
  exp_t popped;
  logic exp_onoff;

  btn_toggle_debounce #(
    .DEBOUNCE_CYCLES (DEB),
    .SYNC_STAGES     (SYN)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_btn         (btn),
    .o_OnOffSW     (onoff),
    .o_btn_level   (level),
    .o_press_pulse (pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Every pulse must match the oldest outstanding press, in cycle and in new switch level.
  always @(negedge clk) begin
    if (!rst && pulse === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", cyc, 0);
      end else begin
        popped = sb.pop_front();
        chk("pulse_cycle", cyc, popped.at);
        chk("pulse_onoff", onoff, popped.onoff);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_accepted();
    btn       = 1'b1;
    exp_onoff = ~exp_onoff;
    sb.push_back('{at: cyc + LAT, onoff: exp_onoff});
  endtask

  initial begin
    rst       = 1'b1;
    btn       = 1'b0;
    exp_onoff = 1'b0;
    cycles(3);
    chk("reset_onoff", onoff, 0);
    chk("reset_level", level, 0);
    chk("reset_pulse", pulse, 0);
    rst = 1'b0;
    cycles(3);

    // Clean press held 20 cycles, then clean release
    press_accepted();
    cycles(20);
    chk("press_level", level, 1);
    chk("press_onoff", onoff, 1);
    chk("held_no_pulse", pulse, 0);
    btn = 1'b0;
    cycles(LAT - 1);
    chk("release_level_early", level, 1);
    cycles(1);
    chk("release_level", level, 0);
    chk("release_onoff", onoff, 1);
    cycles(5);

    // Bounce: high 3, low 1, high 3, low
    btn = 1'b1; cycles(3);
    btn = 1'b0; cycles(1);
    btn = 1'b1; cycles(3);
    btn = 1'b0; cycles(12);
    chk("bounce_onoff", onoff, 1);
    chk("bounce_level", level, 0);

    // High for exactly DEB cycles: drops at cnt==DEB-1, rejected
    btn = 1'b1; cycles(DEB);
    btn = 1'b0; cycles(12);
    chk("edge_reject_onoff", onoff, 1);
    chk("edge_reject_level", level, 0);

    // High for DEB+1 cycles: shortest accepted press
    press_accepted();
    cycles(DEB + 1);
    btn = 1'b0; cycles(12);
    chk("min_press_onoff", onoff, 0);
    chk("min_press_level", level, 0);

    // Two clean presses separated by clean releases
    press_accepted(); cycles(10);
    btn = 1'b0;       cycles(12);
    chk("two_first_onoff", onoff, 1);
    press_accepted(); cycles(10);
    btn = 1'b0;       cycles(12);
    chk("two_second_onoff", onoff, 0);

    // Release bounce: low 2, high 1, then low
    press_accepted(); cycles(10);
    chk("rb_pressed_level", level, 1);
    btn = 1'b0; cycles(2);
    btn = 1'b1; cycles(1);
    btn = 1'b0; cycles(6);
    chk("rb_level_held", level, 1);
    cycles(1);
    chk("rb_level_released", level, 0);
    chk("rb_onoff", onoff, 1);
    cycles(5);

    // Reset while in S_WAIT_DN with cnt = DEB-1
    btn = 1'b1;
    cycles(SYN + DEB);
    #2 rst = 1'b1;
    #1;
    chk("midcnt_rst_onoff", onoff, 0);
    chk("midcnt_rst_level", level, 0);
    chk("midcnt_rst_pulse", pulse, 0);
    exp_onoff = 1'b0;
    cycles(2);
    rst = 1'b0;
    exp_onoff = ~exp_onoff;
    sb.push_back('{at: cyc + LAT, onoff: exp_onoff});
    cycles(LAT - 1);
    chk("post_rst_level_early", level, 0);
    cycles(1);
    chk("post_rst_level", level, 1);
    chk("post_rst_onoff", onoff, 1);
    cycles(4);

    // Asynchronous reset mid-run while pressed and on
    #2 rst = 1'b1;
    #1;
    chk("async_rst_onoff", onoff, 0);
    chk("async_rst_level", level, 0);
    chk("async_rst_pulse", pulse, 0);
    btn = 1'b0;
    cycles(2);
    rst = 1'b0;
    cycles(12);
    chk("after_rst_onoff", onoff, 0);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
